// File: rtl/ff_pkg.sv
// Shared definitions for the universal flip-flop primitives: mode encoding
// and the per-bit next-state / SR-violation rules.
package ff_pkg;

    typedef enum logic [1:0] {
        FF_JK = 2'd0,
        FF_D  = 2'd1,
        FF_T  = 2'd2,
        FF_SR = 2'd3
    } ff_mode_e;

    // Next state of one bit. 'a' is J/D/T/S and 'b' is K/-/-/R.
    // SR with a=b=1 holds; the violation itself is reported separately.
    function automatic logic ff_next(
        input ff_mode_e mode,
        input logic     q,
        input logic     a,
        input logic     b
    );
        logic nxt;
        nxt = q;
        case (mode)
            FF_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            FF_D:  nxt = a;
            FF_T:  nxt = q ^ a;
            FF_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

    function automatic logic ff_sr_violation(
        input ff_mode_e mode,
        input logic     a,
        input logic     b
    );
        return (mode == FF_SR) && a && b;
    endfunction

endpackage

// File: rtl/univ_ff.sv
// One universal flip-flop bit: q and qn are independent registers so they stay
// skew-matched; next-differs and SR-violation flags go up to the bank.
module univ_ff
    import ff_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  ff_mode_e mode,
    input  logic     a,
    input  logic     b,
    output logic     q,
    output logic     qn,
    output logic     differs,
    output logic     sr_viol
);

    logic q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = ff_next(mode, q, a, b);
        end
    end

    assign differs = (q_next != q);
    assign sr_viol = en && ff_sr_violation(mode, a, b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q  <= RST_VAL;
            qn <= ~RST_VAL;
        end else begin
            q  <= q_next;
            qn <= ~q_next;
        end
    end

endmodule

// File: rtl/univ_ff_bank.sv
// Bank of WIDTH universal flip-flops sharing clock, reset, enable and mode,
// with a registered change strobe and a sticky SR-violation flag.
module univ_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic             sr_err
);

    ff_mode_e         mode_e;
    logic [WIDTH-1:0] differs;
    logic [WIDTH-1:0] sr_viol;
    logic             any_change;
    logic             any_viol;
    logic             sr_err_next;

    assign mode_e = ff_mode_e'(mode);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            univ_ff #(
                .RST_VAL (RST_VAL[gi])
            ) u_ff (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .mode    (mode_e),
                .a       (a[gi]),
                .b       (b[gi]),
                .q       (q[gi]),
                .qn      (qn[gi]),
                .differs (differs[gi]),
                .sr_viol (sr_viol[gi])
            );
        end
    endgenerate

    assign any_change = |differs;
    assign any_viol   = |sr_viol;

    // A fresh violation beats a simultaneous clear.
    always_comb begin
        sr_err_next = sr_err;
        if (any_viol) begin
            sr_err_next = 1'b1;
        end else if (err_clr) begin
            sr_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            sr_err  <= 1'b0;
        end else begin
            changed <= any_change;
            sr_err  <= sr_err_next;
        end
    end

endmodule
